// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined RV32I core.
// Registers the decode control bundle and operands into EX, inserts bubbles
// on load-use hazards, applies branch/jump flushes and holds a sticky halt
// once a PCWrite=0 (ECALL/FENCE-class) op reaches EX.
module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [10:0]       id_ctrl,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [3*RA_W-1:0] id_regs,
   input  logic [3:0]        id_funct,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              flush,
   output logic              ex_valid,
   output logic [10:0]       ex_ctrl,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [3*RA_W-1:0] ex_regs,
   output logic [3:0]        ex_funct,
   output logic              stall_if,
   output logic              halted
);

   // Control bundle bit positions:
   // {Branch,MemRead,MemtoReg,ALUOp[1:0],MemWrite,ALUSrc,RegWrite,PCWrite,rfWriteSelect[1:0]}
   localparam int CTRL_MEMREAD = 9;
   localparam int CTRL_PCWRITE = 2;

   logic [RA_W-1:0] id_rs1;
   logic [RA_W-1:0] id_rs2;
   logic [RA_W-1:0] ex_rd;
   logic            load_use;
   logic            ex_halt;

   assign id_rs1 = id_regs[3*RA_W-1:2*RA_W];
   assign id_rs2 = id_regs[2*RA_W-1:RA_W];
   assign ex_rd  = ex_regs[RA_W-1:0];

   // Hazard detection and fetch stall; uses only EX registers, ID register
   // numbers/use flags, id_valid and flush (no path from ID data buses).
   always_comb begin
      load_use = 1'b0;
      ex_halt  = 1'b0;
      stall_if = 1'b0;
      load_use = ex_valid && ex_ctrl[CTRL_MEMREAD] && (ex_rd != '0) && id_valid &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
      ex_halt  = ex_valid && !ex_ctrl[CTRL_PCWRITE];
      stall_if = !flush && (load_use || halted || ex_halt);
   end

   // Pipeline register update: reset, flush, halt, load-use bubble, capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_ctrl     <= '0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_regs     <= '0;
         ex_funct    <= '0;
         halted      <= 1'b0;
      end else if (flush || halted || ex_halt || load_use) begin
         // All bubble cases share the same zeroed EX contents; only the halt
         // case (without flush) additionally sets the sticky halted bit.
         ex_valid    <= 1'b0;
         ex_ctrl     <= '0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_regs     <= '0;
         ex_funct    <= '0;
         if (!flush && (halted || ex_halt)) begin
            halted <= 1'b1;
         end
      end else begin
         ex_valid    <= id_valid;
         ex_ctrl     <= id_valid ? id_ctrl : '0;
         ex_pc       <= id_pc;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
         ex_regs     <= id_regs;
         ex_funct    <= id_funct;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: a per-cycle table of decode inputs with
// hand-derived expectations; expected EX contents are queued when a row is
// driven and compared after the clock edge that should produce them.
module tb_id_ex_stage;

   localparam int XLEN = 32;
   localparam int RA_W = 5;

   localparam logic [10:0] C_LW     = 11'h31C;
   localparam logic [10:0] C_ADD    = 11'h08C;
   localparam logic [10:0] C_ADDI   = 11'h09C;
   localparam logic [10:0] C_ECALL  = 11'h000;
   localparam logic [10:0] C_EBREAK = 11'h004;

   logic              clk;
   logic              rst;
   logic              id_valid;
   logic [10:0]       id_ctrl;
   logic [XLEN-1:0]   id_pc;
   logic [XLEN-1:0]   id_rs1_data;
   logic [XLEN-1:0]   id_rs2_data;
   logic [XLEN-1:0]   id_imm;
   logic [3*RA_W-1:0] id_regs;
   logic [3:0]        id_funct;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic              flush;
   logic              ex_valid;
   logic [10:0]       ex_ctrl;
   logic [XLEN-1:0]   ex_pc;
   logic [XLEN-1:0]   ex_rs1_data;
   logic [XLEN-1:0]   ex_rs2_data;
   logic [XLEN-1:0]   ex_imm;
   logic [3*RA_W-1:0] ex_regs;
   logic [3:0]        ex_funct;
   logic              stall_if;
   logic              halted;

   id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_regs(id_regs), .id_funct(id_funct),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .flush(flush),
      .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_regs(ex_regs), .ex_funct(ex_funct), .stall_if(stall_if), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        flush;
      logic        valid;
      logic [10:0] ctrl;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        use1;
      logic        use2;
      logic [31:0] imm;
      logic        exp_stall;   // stall_if before the edge
      logic        exp_cap;     // data fields captured from this row
      logic        exp_valid;
      logic [10:0] exp_ctrl;
      logic        exp_halt;
   } vec_t;

   typedef struct {
      logic        valid;
      logic [10:0] ctrl;
      logic [31:0] pc;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] imm;
      logic [14:0] regs;
      logic [3:0]  funct;
      logic        halt;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks;
   int   errors;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic fl, input logic v, input logic [10:0] c,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                      input logic u1, input logic u2, input logic [31:0] im,
                      input logic es, input logic ecap, input logic ev,
                      input logic [10:0] ec, input logic eh);
      vec_t t;
      t = '{r, fl, v, c, s1, s2, d, u1, u2, im, es, ecap, ev, ec, eh};
      vecs.push_back(t);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      //   rst fl v  ctrl      rs1 rs2 rd  u1 u2 imm   stall cap v  ectrl     halt
      add(1, 0, 0, 11'h000,  0,  0,  0, 0, 0, 0,     0,    0,  0, 11'h000,  0); // reset state
      // load-use on rs1: one bubble, then add enters with rd=6
      add(0, 0, 1, C_LW,     1,  0,  5, 1, 0, 0,     0,    1,  1, C_LW,     0);
      add(0, 0, 1, C_ADD,    5,  2,  6, 1, 1, 0,     1,    0,  0, 11'h000,  0);
      add(0, 0, 1, C_ADD,    5,  2,  6, 1, 1, 0,     0,    1,  1, C_ADD,    0);
      // load into x0 never stalls
      add(0, 0, 1, C_LW,     1,  0,  0, 1, 0, 0,     0,    1,  1, C_LW,     0);
      add(0, 0, 1, C_ADD,    0,  2,  6, 1, 1, 0,     0,    1,  1, C_ADD,    0);
      // load-use together with flush: flush wins, next instruction captured
      add(0, 0, 1, C_LW,     1,  0,  7, 1, 0, 4,     0,    1,  1, C_LW,     0);
      add(0, 1, 1, C_ADD,    7,  7,  8, 1, 1, 0,     0,    0,  0, 11'h000,  0);
      add(0, 0, 1, C_ADDI,   7,  0,  9, 1, 0, 1,     0,    1,  1, C_ADDI,   0);
      // matching register numbers without use flags: no stall
      add(0, 0, 1, C_LW,     1,  0, 10, 1, 0, 0,     0,    1,  1, C_LW,     0);
      add(0, 0, 1, C_ADDI,  10, 10, 11, 0, 0, 3,     0,    1,  1, C_ADDI,   0);
      // hazard through rs2 only
      add(0, 0, 1, C_LW,     1,  0, 12, 1, 0, 8,     0,    1,  1, C_LW,     0);
      add(0, 0, 1, C_ADD,    3, 12, 13, 1, 1, 0,     1,    0,  0, 11'h000,  0);
      add(0, 0, 1, C_ADD,    3, 12, 13, 1, 1, 0,     0,    1,  1, C_ADD,    0);
      // invalid decode slot never stalls and yields a zero control bundle
      add(0, 0, 1, C_LW,     1,  0, 14, 1, 0, 0,     0,    1,  1, C_LW,     0);
      add(0, 0, 0, C_ADD,   14,  0, 15, 1, 0, 0,     0,    1,  0, 11'h000,  0);
      // EBREAK does not halt; addi x3,x0,7 reaches EX
      add(0, 0, 1, C_EBREAK, 0,  0,  0, 0, 0, 0,     0,    1,  1, C_EBREAK, 0);
      add(0, 0, 1, C_ADDI,   0,  0,  3, 1, 0, 7,     0,    1,  1, C_ADDI,   0);
      // ECALL halts; flush while halted releases stall_if but keeps halted
      add(0, 0, 1, C_ECALL,  0,  0,  0, 0, 0, 0,     0,    1,  1, C_ECALL,  0);
      add(0, 0, 1, C_ADDI,   0,  0,  4, 1, 0, 1,     1,    0,  0, 11'h000,  1);
      add(0, 0, 1, C_ADDI,   0,  0,  4, 1, 0, 1,     1,    0,  0, 11'h000,  1);
      add(0, 1, 1, C_ADDI,   0,  0,  4, 1, 0, 1,     0,    0,  0, 11'h000,  1);
      add(0, 0, 1, C_ADDI,   0,  0,  4, 1, 0, 1,     1,    0,  0, 11'h000,  1);
      // reset while halted, then reset during a load-use stall
      add(1, 0, 1, C_ADDI,   0,  0,  4, 1, 0, 1,     1,    0,  0, 11'h000,  0);
      add(0, 0, 1, C_LW,     1,  0,  5, 1, 0, 0,     0,    1,  1, C_LW,     0);
      add(1, 0, 1, C_ADD,    5,  2,  6, 1, 1, 0,     1,    0,  0, 11'h000,  0);
      add(0, 0, 1, C_ADD,    5,  2,  6, 1, 1, 0,     0,    1,  1, C_ADD,    0);
      // ECALL in EX with flush the same cycle: halted not set
      add(0, 0, 1, C_ECALL,  0,  0,  0, 0, 0, 0,     0,    1,  1, C_ECALL,  0);
      add(0, 1, 1, C_ADDI,   0,  0,  4, 1, 0, 2,     0,    0,  0, 11'h000,  0);
      add(0, 0, 1, C_ADDI,   0,  0,  4, 1, 0, 2,     0,    1,  1, C_ADDI,   0);

      rst = 1'b1; flush = 1'b0; id_valid = 1'b0; id_ctrl = '0; id_pc = '0;
      id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_regs = '0;
      id_funct = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         exp_t e;
         exp_t g;
         v = vecs[i];
         @(negedge clk);
         rst         = v.rst;
         flush       = v.flush;
         id_valid    = v.valid;
         id_ctrl     = v.ctrl;
         id_pc       = 32'h0000_1000 + 32'(i) * 4;
         id_rs1_data = id_pc ^ 32'hA5A5_0000;
         id_rs2_data = id_pc ^ 32'h5A5A_0000;
         id_imm      = v.imm;
         id_regs     = {v.rs1, v.rs2, v.rd};
         id_funct    = id_pc[5:2];
         id_use_rs1  = v.use1;
         id_use_rs2  = v.use2;
         #1;
         check($sformatf("stall_if[%0d]", i), 32'(stall_if), 32'(v.exp_stall));
         e.valid = v.exp_valid;
         e.ctrl  = v.exp_ctrl;
         e.halt  = v.exp_halt;
         e.pc    = v.exp_cap ? id_pc       : '0;
         e.rs1d  = v.exp_cap ? id_rs1_data : '0;
         e.rs2d  = v.exp_cap ? id_rs2_data : '0;
         e.imm   = v.exp_cap ? id_imm      : '0;
         e.regs  = v.exp_cap ? id_regs     : '0;
         e.funct = v.exp_cap ? id_funct    : '0;
         sb.push_back(e);
         @(posedge clk);
         #1;
         g = sb.pop_front();
         check($sformatf("ex_valid[%0d]", i),    32'(ex_valid),  32'(g.valid));
         check($sformatf("ex_ctrl[%0d]", i),     32'(ex_ctrl),   32'(g.ctrl));
         check($sformatf("ex_pc[%0d]", i),       ex_pc,          g.pc);
         check($sformatf("ex_rs1_data[%0d]", i), ex_rs1_data,    g.rs1d);
         check($sformatf("ex_rs2_data[%0d]", i), ex_rs2_data,    g.rs2d);
         check($sformatf("ex_imm[%0d]", i),      ex_imm,         g.imm);
         check($sformatf("ex_regs[%0d]", i),     32'(ex_regs),   32'(g.regs));
         check($sformatf("ex_funct[%0d]", i),    32'(ex_funct),  32'(g.funct));
         check($sformatf("halted[%0d]", i),      32'(halted),    32'(g.halt));
      end

      // after the final reset-free row nothing is pending
      @(negedge clk);
      id_valid = 1'b0;
      flush    = 1'b0;
      #1;
      check("stall_if_idle", 32'(stall_if), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
